// File: rtl/seg_scan_display_if.sv
// Bus bundle for seg_scan_display: control/write inputs and the scan outputs.
// Optional blink_mask is present only when SEG_SCAN_BLINK_EN is defined.
interface seg_scan_display_if #(
  parameter int unsigned NUM_DIGITS = 10,
  parameter int unsigned AW         = 5,
  parameter int unsigned DIV_W      = 16
);
  logic                  enable;
  logic [DIV_W-1:0]      scan_div;
  logic [3:0]            bright;
  logic                  raw_mode;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [7:0]            wr_data;
`ifdef SEG_SCAN_BLINK_EN
  logic [NUM_DIGITS-1:0] blink_mask;
`endif
  logic [NUM_DIGITS-1:0] sel;
  logic [7:0]            segm;
  logic                  frame_o;

`ifdef SEG_SCAN_BLINK_EN
  modport master (
    output enable, scan_div, bright, raw_mode, wr_en, wr_addr, wr_data, blink_mask,
    input  sel, segm, frame_o
  );
  modport slave (
    input  enable, scan_div, bright, raw_mode, wr_en, wr_addr, wr_data, blink_mask,
    output sel, segm, frame_o
  );
`else
  modport master (
    output enable, scan_div, bright, raw_mode, wr_en, wr_addr, wr_data,
    input  sel, segm, frame_o
  );
  modport slave (
    input  enable, scan_div, bright, raw_mode, wr_en, wr_addr, wr_data,
    output sel, segm, frame_o
  );
`endif
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver with per-digit register file, PWM brightness,
// a dark dead-time tick between digits, hex/raw modes and a frame strobe.
// Optional blinking is compiled in with the SEG_SCAN_BLINK_EN macro.
module seg_scan_display #(
  parameter int unsigned NUM_DIGITS  = 10,
  parameter int unsigned AW          = 5,
  parameter int unsigned DIV_W       = 16,
  parameter bit          SEL_ACT_LOW = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_display_if.slave bus
);
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Inactive levels; XOR with these converts active-high patterns to pin polarity
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACT_LOW}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACT_LOW}};

  logic [7:0]            r_regs [NUM_DIGITS];
  logic [DIV_W-1:0]      r_pre;
  logic [DIV_W-1:0]      r_div;
  logic [3:0]            r_tick;
  logic [DW-1:0]         r_digit;
  logic [7:0]            r_cur;
  logic                  r_raw;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [7:0]            r_segm;
  logic                  r_frame;

  logic                  w_tick;
  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [DW-1:0]         w_digit_nxt;
  logic                  w_wr_hit0;
  logic [6:0]            w_hex;
  logic [7:0]            w_pat;
  logic                  w_lit;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_onehot;

  // Scan timing decode: prescaler wrap, end of slot, end of frame
  always_comb begin
    w_tick      = (r_pre == r_div);
    w_slot_end  = w_tick && (r_tick == 4'd15);
    w_frame_end = w_slot_end && (r_digit == DW'(NUM_DIGITS - 1));
    w_digit_nxt = w_frame_end ? '0 : r_digit + 1'b1;
    w_wr_hit0   = bus.wr_en && (bus.wr_addr == '0);
  end

  // Digit register file; out-of-range addresses match no entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) r_regs[i] <= 8'h00;
    end else if (bus.wr_en) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (bus.wr_addr == AW'(i)) r_regs[i] <= bus.wr_data;
      end
    end
  end

  // Prescaler, tick/digit counters and per-slot latch of the displayed byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_div   <= '0;
      r_tick  <= '0;
      r_digit <= '0;
      r_cur   <= 8'h00;
      r_raw   <= 1'b0;
    end else if (!bus.enable) begin
      r_pre   <= '0;
      r_div   <= bus.scan_div;
      r_tick  <= '0;
      r_digit <= '0;
      // Keep digit 0's byte ready so the restarted scan shows it from tick 0
      r_cur   <= w_wr_hit0 ? bus.wr_data : r_regs[0];
      r_raw   <= bus.raw_mode;
    end else if (w_tick) begin
      r_pre  <= '0;
      r_div  <= bus.scan_div;
      r_tick <= r_tick + 4'd1;
      if (w_slot_end) begin
        r_digit <= w_digit_nxt;
        r_cur   <= r_regs[w_digit_nxt];
        r_raw   <= bus.raw_mode;
      end
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int unsigned FCW = (BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
  logic [FCW-1:0] r_fcnt;

  // Frame counter over one blink period; second half blanks masked digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= '0;
    end else if (!bus.enable) begin
      r_fcnt <= '0;
    end else if (w_frame_end) begin
      r_fcnt <= (r_fcnt == FCW'(2 * BLINK_FRAMES - 1)) ? '0 : r_fcnt + 1'b1;
    end
  end

  assign w_blank = (r_fcnt >= FCW'(BLINK_FRAMES)) && bus.blink_mask[r_digit];
`else
  assign w_blank = 1'b0;
`endif

  // Segment pattern for the latched byte and PWM gating by tick position
  always_comb begin
    case (r_cur[3:0])
      4'h0:    w_hex = 7'h3F;
      4'h1:    w_hex = 7'h06;
      4'h2:    w_hex = 7'h5B;
      4'h3:    w_hex = 7'h4F;
      4'h4:    w_hex = 7'h66;
      4'h5:    w_hex = 7'h6D;
      4'h6:    w_hex = 7'h7D;
      4'h7:    w_hex = 7'h07;
      4'h8:    w_hex = 7'h7F;
      4'h9:    w_hex = 7'h6F;
      4'hA:    w_hex = 7'h77;
      4'hB:    w_hex = 7'h7C;
      4'hC:    w_hex = 7'h39;
      4'hD:    w_hex = 7'h5E;
      4'hE:    w_hex = 7'h79;
      default: w_hex = 7'h71;
    endcase
    w_pat             = r_raw ? r_cur : {r_cur[4], w_hex};
    // bright is at most 15, so tick 15 is always dark
    w_lit             = (r_tick < bus.bright) && !w_blank;
    w_onehot          = '0;
    w_onehot[r_digit] = 1'b1;
  end

  // Registered outputs, one clk behind the counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= SEL_OFF;
      r_segm  <= SEG_OFF;
      r_frame <= 1'b0;
    end else if (!bus.enable) begin
      r_sel   <= SEL_OFF;
      r_segm  <= SEG_OFF;
      r_frame <= 1'b0;
    end else begin
      r_sel   <= w_onehot ^ SEL_OFF;
      r_segm  <= w_lit ? (w_pat ^ SEG_OFF) : SEG_OFF;
      r_frame <= w_frame_end;
    end
  end

  assign bus.sel     = r_sel;
  assign bus.segm    = r_segm;
  assign bus.frame_o = r_frame;
endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (4 digits, active-low sel and segm).
module tb_seg_scan_display;
  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 3;
  localparam int unsigned DVW = 16;
  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_display_if #(.NUM_DIGITS(N), .AW(AW), .DIV_W(DVW)) bus ();

  seg_scan_display #(
    .NUM_DIGITS (N),
    .AW         (AW),
    .DIV_W      (DVW),
    .SEL_ACT_LOW(1'b1),
    .SEG_ACT_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int j = 0;              // enabled clock edges since the scan (re)started
  logic [7:0] ref_mem [N];

  typedef struct {
    logic       raw;
    logic [7:0] data;
    logic [7:0] exp_seg;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (j=%0d, t=%0t)", name, act, exp, j, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    j++;
  endtask

  task automatic step_to(input int k);
    while (j < k) step();
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
    if (int'(addr) < int'(N)) ref_mem[addr[1:0]] = data;
  endtask

  // Disable for one edge with new settings, then enable; j counts from here
  task automatic restart(input int d, input int br, input logic raw);
    bus.enable   = 1'b0;
    bus.scan_div = DVW'(d);
    bus.bright   = 4'(br);
    bus.raw_mode = raw;
    step();
    bus.enable   = 1'b1;
    j = 0;
  endtask

  function automatic logic [7:0] exp_seg(input logic [7:0] b, input logic raw, input logic lit);
    logic [7:0] pat;
    pat = raw ? b : {b[4], HEX_TAB[b[3:0]]};
    return lit ? ~pat : 8'hFF;
  endfunction

  function automatic logic [N-1:0] exp_sel(input int d);
    logic [N-1:0] oh;
    oh = '0;
    oh[d] = 1'b1;
    return ~oh;
  endfunction

  // Reference: outputs after enabled edge k follow from elapsed ticks with plain arithmetic
  task automatic run_model(input int cycles, input int d, input int br, input logic raw);
    int t, dig, tk;
    logic [12:0] exp_v, act_v;
    for (int k = 0; k < cycles; k++) begin
      step();
      t     = (j - 1) / (d + 1);
      dig   = (t / 16) % int'(N);
      tk    = t % 16;
      exp_v = {exp_sel(dig), exp_seg(ref_mem[dig], raw, tk < br),
               1'b0 + ((j % (16 * int'(N) * (d + 1))) == 0)};
      act_v = {bus.sel, bus.segm, bus.frame_o};
      chk("model {sel,segm,frame}", 32'(act_v), 32'(exp_v));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int f1, f2;
    int rd, rbr;
    logic rraw;

    vecs[0] = '{1'b0, 8'h01, 8'hF9};
    vecs[1] = '{1'b0, 8'h1A, 8'h08};
    vecs[2] = '{1'b0, 8'h0B, 8'h83};
    vecs[3] = '{1'b0, 8'h1F, 8'h0E};
    vecs[4] = '{1'b1, 8'h80, 8'h7F};
    vecs[5] = '{1'b1, 8'h3F, 8'hC0};
    vecs[6] = '{1'b0, 8'h0D, 8'hA1};
    vecs[7] = '{1'b0, 8'h15, 8'h12};

    for (int i = 0; i < int'(N); i++) ref_mem[i] = 8'h00;
    bus.enable   = 1'b0;
    bus.scan_div = '0;
    bus.bright   = 4'd0;
    bus.raw_mode = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = 8'h00;
`ifdef SEG_SCAN_BLINK_EN
    bus.blink_mask = '0;
`endif

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset sel", 32'(bus.sel), 32'h0F);
    chk("reset segm", 32'(bus.segm), 32'hFF);
    chk("reset frame", 32'(bus.frame_o), 32'h0);
    rst_n = 1'b1;

    // First slot after reset shows '0' on digit 0
    restart(0, 15, 1'b0);
    step_to(1);
    chk("first slot sel", 32'(bus.sel), 32'hE);
    chk("first slot segm", 32'(bus.segm), 32'hC0);

    // Table of single-digit patterns: tick 0 lit, tick 15 dark
    for (int i = 0; i < 8; i++) begin
      int a;
      a = i % int'(N);
      bus.enable = 1'b0;
      wr(AW'(a), vecs[i].data);
      restart(0, 15, vecs[i].raw);
      step_to(16 * a + 1);
      chk($sformatf("vec%0d sel", i), 32'(bus.sel), 32'(exp_sel(a)));
      chk($sformatf("vec%0d segm", i), 32'(bus.segm), 32'(vecs[i].exp_seg));
      step_to(16 * a + 15);
      chk($sformatf("vec%0d tick14", i), 32'(bus.segm), 32'(vecs[i].exp_seg));
      step_to(16 * a + 16);
      chk($sformatf("vec%0d tick15", i), 32'(bus.segm), 32'hFF);
    end

    // bright=4: exactly 4 lit ticks in digit 0's slot
    restart(0, 4, 1'b0);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus.segm != 8'hFF) cnt++;
    end
    chk("bright4 lit ticks", 32'(cnt), 32'd4);

    // bright=0: always dark, sel still rotates
    restart(0, 0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (bus.segm != 8'hFF) cnt++;
      if ((j - 1) % 16 == 0) chk($sformatf("bright0 sel@%0d", j), 32'(bus.sel),
                                 32'(exp_sel((j - 1) / 16)));
    end
    chk("bright0 lit ticks", 32'(cnt), 32'd0);

    // scan_div=2: frame every 4*16*3 = 192 clks
    restart(2, 15, 1'b0);
    f1 = -1;
    f2 = -1;
    for (int c = 0; c < 1000 && f2 < 0; c++) begin
      step();
      if (bus.frame_o) begin
        if (f1 < 0) f1 = j;
        else f2 = j;
      end
    end
    chk("frame first", 32'(f1), 32'd192);
    chk("frame period", 32'(f2 - f1), 32'd192);

    // Out-of-range write is ignored
    bus.enable = 1'b0;
    wr(3'd0, 8'h05);
    wr(3'd4, 8'h08);
    restart(0, 15, 1'b0);
    step_to(1);
    chk("addr4 ignored", 32'(bus.segm), 32'h92);
    run_model(63, 0, 15, 1'b0);

    // Raw mode dp-only, then a mid-slot write held until the next scan
    bus.enable = 1'b0;
    wr(3'd2, 8'h80);
    restart(0, 15, 1'b1);
    step_to(33);
    chk("raw dp sel", 32'(bus.sel), 32'hB);
    chk("raw dp segm", 32'(bus.segm), 32'h7F);
    step_to(37);
    wr(3'd2, 8'h3F);
    step_to(40);
    chk("midslot hold", 32'(bus.segm), 32'h7F);
    step_to(97);
    chk("midslot next scan", 32'(bus.segm), 32'hC0);

    // Enable drop mid-slot, then restart at digit 0 tick 0
    step_to(103);
    bus.enable = 1'b0;
    step();
    chk("disable sel", 32'(bus.sel), 32'hF);
    chk("disable segm", 32'(bus.segm), 32'hFF);
    bus.enable = 1'b1;
    j = 0;
    step();
    chk("reenable sel", 32'(bus.sel), 32'hE);
    chk("reenable segm", 32'(bus.segm), 32'(exp_seg(ref_mem[0], 1'b1, 1'b1)));

    // Randomized configurations against the reference model
    for (int r = 0; r < 6; r++) begin
      rd   = int'($urandom_range(0, 3));
      rbr  = int'($urandom_range(0, 15));
      rraw = 1'($urandom_range(0, 1));
      bus.enable = 1'b0;
      for (int w = 0; w < 5; w++) wr(AW'($urandom_range(0, 7)), 8'($urandom));
      restart(rd, rbr, rraw);
      run_model(2 * 16 * int'(N) * (rd + 1), rd, rbr, rraw);
    end

    // Async reset mid-scan: immediate dark outputs, register contents lost
    bus.raw_mode = 1'b0;
    wr(3'd1, 8'h08);
    restart(0, 15, 1'b0);
    step_to(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst sel", 32'(bus.sel), 32'hF);
    chk("async rst segm", 32'(bus.segm), 32'hFF);
    chk("async rst frame", 32'(bus.frame_o), 32'h0);
    for (int i = 0; i < int'(N); i++) ref_mem[i] = 8'h00;
    #3;
    rst_n = 1'b1;
    j = 0;
    run_model(64, 0, 15, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
